// File: rtl/ls_pkg.sv
// Shared types and width helpers for the least-squares moment accumulator.
package ls_pkg;

    localparam int unsigned PIPE_LAT = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_DONE
    } ls_state_t;

    // Bits needed to hold values 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

    // Widest operand plus one carry bit, used for overflow-detecting lane sums.
    function automatic int unsigned sum_width(input int unsigned a, input int unsigned b,
                                              input int unsigned acc);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > acc) ? m : acc;
        return m + 1;
    endfunction

endpackage

// File: rtl/ls_power_stage.sv
// Registered power stage: xi^0..xi^(2*DEG) and xi^k*yi for k=0..DEG, full width.
module ls_power_stage
    import ls_pkg::*;
#(
    parameter int unsigned XW  = 8,
    parameter int unsigned YW  = 8,
    parameter int unsigned DEG = 2,
    parameter int unsigned PW  = 2 * DEG * XW,
    parameter int unsigned XYW = DEG * XW + YW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_v,
    input  logic [XW-1:0]              x,
    input  logic [YW-1:0]              y,
    output logic                       out_v,
    output logic [(2*DEG+1)*PW-1:0]    pow,
    output logic [(DEG+1)*XYW-1:0]     xy
);

    logic [PW-1:0]               p;
    logic [(2*DEG+1)*PW-1:0]     pow_c;
    logic [(DEG+1)*XYW-1:0]      xy_c;

    // Running product chain; x^k always fits in PW bits for k <= 2*DEG.
    always_comb begin
        p     = PW'(1);
        pow_c = '0;
        xy_c  = '0;
        for (int k = 0; k < int'(2 * DEG + 1); k++) begin
            pow_c[k*PW +: PW] = p;
            if (k <= int'(DEG)) begin
                xy_c[k*XYW +: XYW] = XYW'(p) * XYW'(y);
            end
            p = p * PW'(x);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_v <= 1'b0;
            pow   <= '0;
            xy    <= '0;
        end else begin
            out_v <= in_v & ~flush;
            pow   <= pow_c;
            xy    <= xy_c;
        end
    end

endmodule

// File: rtl/ls_moment_accum.sv
// Streaming accumulator of polynomial least-squares moments sum(x^k) and sum(x^k*y).
// LS_MOMENT_SAT_EN selects saturating lanes with sticky ovf; otherwise lanes wrap.
module ls_moment_accum
    import ls_pkg::*;
#(
    parameter int unsigned XW    = 8,
    parameter int unsigned YW    = 8,
    parameter int unsigned DEG   = 2,
    parameter int unsigned NS    = 256,
    parameter int unsigned ACC_W = 48
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_last,
    input  logic [XW-1:0]                 xi,
    input  logic [YW-1:0]                 yi,
    output logic [(2*DEG+1)*ACC_W-1:0]    sxx,
    output logic [(DEG+1)*ACC_W-1:0]      sxy,
    output logic [cnt_width(NS)-1:0]      count,
    output logic                          done,
    output logic                          trunc,
    output logic                          ovf
);

    localparam int unsigned NX  = 2 * DEG + 1;
    localparam int unsigned NY  = DEG + 1;
    localparam int unsigned PW  = 2 * DEG * XW;
    localparam int unsigned XYW = DEG * XW + YW;
    localparam int unsigned CW  = cnt_width(NS);
    localparam int unsigned DW  = cnt_width(PIPE_LAT - 1);

    ls_state_t          state;
    logic [DW-1:0]      drain_cnt;
    logic               accept_c;
    logic               frame_clr_c;

    logic               v_q;
    logic [XW-1:0]      x_q;
    logic [YW-1:0]      y_q;

    logic               p_v;
    logic [NX*PW-1:0]   pow_q;
    logic [NY*XYW-1:0]  xy_q;

    logic [NX*ACC_W-1:0] sxx_nxt;
    logic [NY*ACC_W-1:0] sxy_nxt;

    assign accept_c    = in_valid & in_ready & (state == S_ACCUM);
    assign frame_clr_c = abort | (start & (state == S_IDLE));

    // Frame control: beat counting, drain timing and the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            trunc     <= 1'b0;
            drain_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= S_IDLE;
                in_ready  <= 1'b0;
                count     <= '0;
                trunc     <= 1'b0;
                drain_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state    <= S_ACCUM;
                            in_ready <= 1'b1;
                            count    <= '0;
                            trunc    <= 1'b0;
                        end
                    end
                    S_ACCUM: begin
                        if (accept_c) begin
                            count <= count + CW'(1);
                            if (in_last || (count == CW'(NS - 1))) begin
                                state     <= S_DRAIN;
                                in_ready  <= 1'b0;
                                drain_cnt <= '0;
                                trunc     <= ~in_last;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (drain_cnt == DW'(PIPE_LAT - 1)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + DW'(1);
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state    <= S_IDLE;
                        in_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Pipeline stage 1: input register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= 1'b0;
            x_q <= '0;
            y_q <= '0;
        end else begin
            v_q <= accept_c & ~abort;
            if (accept_c) begin
                x_q <= xi;
                y_q <= yi;
            end
        end
    end

    ls_power_stage #(
        .XW  (XW),
        .YW  (YW),
        .DEG (DEG),
        .PW  (PW),
        .XYW (XYW)
    ) u_power (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .in_v  (v_q),
        .x     (x_q),
        .y     (y_q),
        .out_v (p_v),
        .pow   (pow_q),
        .xy    (xy_q)
    );

`ifdef LS_MOMENT_SAT_EN
    localparam int unsigned SW = sum_width(PW, XYW, ACC_W);
    logic [SW-1:0] sum_c;
    logic          lane_ovf_c;

    // Any carry or product bit above ACC_W pins the lane at all-ones.
    always_comb begin
        sxx_nxt    = sxx;
        sxy_nxt    = sxy;
        lane_ovf_c = 1'b0;
        sum_c      = '0;
        for (int k = 0; k < int'(NX); k++) begin
            sum_c = SW'(sxx[k*ACC_W +: ACC_W]) + SW'(pow_q[k*PW +: PW]);
            if (sum_c[SW-1:ACC_W] != '0) begin
                sxx_nxt[k*ACC_W +: ACC_W] = '1;
                lane_ovf_c                = 1'b1;
            end else begin
                sxx_nxt[k*ACC_W +: ACC_W] = sum_c[ACC_W-1:0];
            end
        end
        for (int k = 0; k < int'(NY); k++) begin
            sum_c = SW'(sxy[k*ACC_W +: ACC_W]) + SW'(xy_q[k*XYW +: XYW]);
            if (sum_c[SW-1:ACC_W] != '0) begin
                sxy_nxt[k*ACC_W +: ACC_W] = '1;
                lane_ovf_c                = 1'b1;
            end else begin
                sxy_nxt[k*ACC_W +: ACC_W] = sum_c[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (frame_clr_c) begin
            ovf <= 1'b0;
        end else if (p_v && lane_ovf_c) begin
            ovf <= 1'b1;
        end
    end
`else
    // Modulo-2^ACC_W lanes; product bits above ACC_W are dropped.
    always_comb begin
        sxx_nxt = sxx;
        sxy_nxt = sxy;
        for (int k = 0; k < int'(NX); k++) begin
            sxx_nxt[k*ACC_W +: ACC_W] = sxx[k*ACC_W +: ACC_W] + ACC_W'(pow_q[k*PW +: PW]);
        end
        for (int k = 0; k < int'(NY); k++) begin
            sxy_nxt[k*ACC_W +: ACC_W] = sxy[k*ACC_W +: ACC_W] + ACC_W'(xy_q[k*XYW +: XYW]);
        end
    end

    assign ovf = 1'b0;
`endif

    // Pipeline stage 3: accumulate; a frame open or abort wipes the lanes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sxx <= '0;
            sxy <= '0;
        end else if (frame_clr_c) begin
            sxx <= '0;
            sxy <= '0;
        end else if (p_v) begin
            sxx <= sxx_nxt;
            sxy <= sxy_nxt;
        end
    end

endmodule
